// File: rtl/apb_slave_mem_param_if.sv
// APB bus bundle for apb_slave_mem_param.
// The master modport drives the request side. The slave modport drives the response side.
interface apb_slave_mem_param_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic                    PWRITE;
  logic                    PSEL;
  logic                    PENABLE;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PADDR, PWDATA, PSTRB, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PSTRB, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_mem_param.sv
// Parametrised APB slave memory with wait states, byte strobes and abort handling.
// Optional feature macro: APB_SLV_PSLVERR_EN. When it is defined, an out-of-range word
// index returns PSLVERR and the write is suppressed. When it is undefined, the index
// wraps modulo DEPTH.
module apb_slave_mem_param #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  apb_slave_mem_param_if.slave  bus
);
  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(STRB_W);
  localparam int IDX_W     = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [STRB_W-1:0]       strb_q;
  logic [3:0]              cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    setup;
  logic                    cnt_done;
  logic                    ready;
  logic                    addr_err;
  logic [ADDR_WIDTH-1:0]   word;
  logic [IDX_W-1:0]        idx;

  assign setup    = bus.PSEL && !bus.PENABLE;
  assign cnt_done = (cnt == 4'(WAIT_CYCLES));
  assign word     = addr_q >> LANE_BITS;
  assign idx      = word[IDX_W-1:0];

`ifdef APB_SLV_PSLVERR_EN
  assign addr_err = (word >= ADDR_WIDTH'(DEPTH));
`else
  assign addr_err = 1'b0;
  // Upper index bits are dropped so the index wraps modulo DEPTH.
  logic unused_upper;
  assign unused_upper = ^word[ADDR_WIDTH-1:IDX_W];
`endif

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Latch the setup-phase address and control. Count wait states while the access phase is held.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      strb_q  <= '0;
      cnt     <= '0;
    end else if ((state == IDLE || state == DONE) && setup) begin
      addr_q  <= bus.PADDR;
      write_q <= bus.PWRITE;
      strb_q  <= bus.PSTRB;
      cnt     <= '0;
    end else if (state == ACCESS && bus.PSEL && bus.PENABLE && !cnt_done) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Next-state logic. PSEL low during ACCESS aborts the transfer. DONE accepts a new setup directly.
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (setup) state_nxt = ACCESS;
      ACCESS: begin
        if (!bus.PSEL)                      state_nxt = IDLE;
        else if (bus.PENABLE && cnt_done)   state_nxt = DONE;
      end
      DONE:    state_nxt = setup ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Response outputs. PRDATA and PSLVERR are non-zero only in the PREADY cycle.
  always_comb begin
    ready       = (state == ACCESS) && bus.PSEL && bus.PENABLE && cnt_done;
    bus.PREADY  = ready;
    bus.PSLVERR = ready && addr_err;
    bus.PRDATA  = (ready && !write_q && !addr_err) ? mem[idx] : '0;
  end

  // Storage array. Masked byte writes commit at the edge that ends the PREADY cycle.
  // NOTE: this array is built from flops, not a RAM macro, because every word must be cleared in the reset cycle.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ready && write_q && !addr_err) begin
      for (int b = 0; b < STRB_W; b++)
        if (strb_q[b]) mem[idx][8*b +: 8] <= bus.PWDATA[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_apb_slave_mem_param.sv
// Directed testbench for apb_slave_mem_param with default parameters (32/32/256/2).
module tb_apb_slave_mem_param;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WAITS = 2;

  logic PCLK = 1'b0;
  logic PRESET;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  apb_slave_mem_param_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_slave_mem_param #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(256), .WAIT_CYCLES(WAITS)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  // Runs one transfer. It returns at the falling edge of the PREADY cycle, so the caller
  // can chain another transfer (its setup then lands in DONE) or go idle.
  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input bit scramble,
                          output logic [31:0] rd, output logic err,
                          output int waits, output int setup_cyc);
    bit ready;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = addr;
    bus.PWRITE = wr; bus.PWDATA = data; bus.PSTRB = strb;
    setup_cyc = cyc;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    if (scramble) begin
      bus.PADDR  = addr ^ 32'h0000_0044;
      bus.PWRITE = ~wr;
    end
    waits = 0; ready = 1'b0; rd = '0; err = 1'b0;
    while (!ready && waits < 20) begin
      @(negedge PCLK);
      if (bus.PREADY) begin
        ready = 1'b1; rd = bus.PRDATA; err = bus.PSLVERR;
      end else begin
        waits++;
        @(posedge PCLK); #1;
      end
    end
    check("ready_seen", 32'(ready), 32'd1);
  endtask

  logic [31:0] rd;
  logic        err;
  int          waits, s1, s2, hits;

  initial begin
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
    bus.PADDR = '0; bus.PWDATA = '0; bus.PSTRB = '0;
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;

    @(negedge PCLK);
    check("rst_pready",  32'(bus.PREADY),  32'd0);
    check("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
    check("rst_prdata",  bus.PRDATA,       32'h0);

    // Read after reset. PREADY is expected WAITS cycles into the access phase (cycle T+3).
    apb_xfer(0, 32'h10, 32'h0, 4'h0, 0, rd, err, waits, s1);
    check("rd_rst_data",  rd,            32'h0);
    check("rd_rst_waits", 32'(waits),    32'(WAITS));
    bus_idle();

    // A lone PENABLE with no preceding setup must be ignored.
    @(posedge PCLK); #1;
    bus.PSEL = 1; bus.PENABLE = 1; bus.PWRITE = 1; bus.PADDR = 32'h20; bus.PSTRB = 4'hF;
    hits = 0;
    repeat (5) begin @(negedge PCLK); if (bus.PREADY) hits++; end
    check("no_setup_pready", 32'(hits), 32'd0);
    bus_idle();

    // Full write, then masked write. PADDR/PWRITE are scrambled during access and must be ignored.
    apb_xfer(1, 32'h20, 32'hDEADBEEF, 4'hF, 1, rd, err, waits, s1);
    check("wr_prdata_zero", rd, 32'h0);
    bus_idle();
    apb_xfer(0, 32'h20, 32'h0, 4'h0, 1, rd, err, waits, s1);
    check("rd_full", rd, 32'hDEADBEEF);
    bus_idle();
    apb_xfer(1, 32'h20, 32'h11223344, 4'b0101, 0, rd, err, waits, s1);
    bus_idle();
    apb_xfer(0, 32'h22, 32'h0, 4'h0, 0, rd, err, waits, s1);
    check("rd_strb_0101", rd, 32'hDE22BE44);
    bus_idle();
    apb_xfer(1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, rd, err, waits, s1);
    bus_idle();
    apb_xfer(0, 32'h20, 32'h0, 4'h0, 0, rd, err, waits, s1);
    check("rd_strb_none", rd, 32'hDE22BE44);
    bus_idle();

    // Abort: PSEL drops on the first access cycle.
    @(posedge PCLK); #1;
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = 32'h30;
    bus.PWDATA = 32'hA5A5A5A5; bus.PSTRB = 4'hF;
    @(posedge PCLK); #1;
    bus.PSEL = 0; bus.PENABLE = 0;
    hits = 0;
    repeat (6) begin @(negedge PCLK); if (bus.PREADY) hits++; end
    check("abort_pready", 32'(hits), 32'd0);
    apb_xfer(0, 32'h30, 32'h0, 4'h0, 0, rd, err, waits, s1);
    check("abort_rd", rd, 32'h0);
    bus_idle();

    // Back-to-back writes, then back-to-back reads. Each second setup lands in DONE.
    apb_xfer(1, 32'h0, 32'h1, 4'hF, 0, rd, err, waits, s1);
    apb_xfer(1, 32'h4, 32'h2, 4'hF, 0, rd, err, waits, s2);
    check("b2b_period", 32'(s2 - s1), 32'(WAITS + 2));
    apb_xfer(0, 32'h0, 32'h0, 4'h0, 0, rd, err, waits, s1);
    check("b2b_rd0", rd, 32'h1);
    apb_xfer(0, 32'h4, 32'h0, 4'h0, 0, rd, err, waits, s2);
    check("b2b_rd1", rd, 32'h2);
    check("b2b_rd_period", 32'(s2 - s1), 32'(WAITS + 2));
    bus_idle();

    // Out-of-range index 256.
    apb_xfer(1, 32'h400, 32'h55AA55AA, 4'hF, 0, rd, err, waits, s1);
`ifdef APB_SLV_PSLVERR_EN
    check("oor_pslverr", 32'(err), 32'd1);
    bus_idle();
    apb_xfer(0, 32'h400, 32'h0, 4'h0, 0, rd, err, waits, s1);
    check("oor_rd_zero", rd, 32'h0);
    check("oor_rd_err", 32'(err), 32'd1);
    bus_idle();
    apb_xfer(0, 32'h0, 32'h0, 4'h0, 0, rd, err, waits, s1);
    check("oor_idx0", rd, 32'h1);
    check("ok_pslverr", 32'(err), 32'd0);
`else
    check("wrap_pslverr", 32'(err), 32'd0);
    bus_idle();
    apb_xfer(0, 32'h0, 32'h0, 4'h0, 0, rd, err, waits, s1);
    check("wrap_idx0", rd, 32'h55AA55AA);
`endif
    bus_idle();

    // Reset asserted during the wait state of a write to 0x8.
    @(posedge PCLK); #1;
    bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = 32'h8;
    bus.PWDATA = 32'hCAFEF00D; bus.PSTRB = 4'hF;
    @(posedge PCLK); #1;
    bus.PENABLE = 1;
    hits = 0;
    @(negedge PCLK); if (bus.PREADY) hits++;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(negedge PCLK); if (bus.PREADY) hits++;
    @(posedge PCLK); #1;
    PRESET = 1'b0; bus.PSEL = 0; bus.PENABLE = 0;
    repeat (3) begin @(negedge PCLK); if (bus.PREADY) hits++; end
    check("rst_mid_pready", 32'(hits), 32'd0);
    apb_xfer(0, 32'h8, 32'h0, 4'h0, 0, rd, err, waits, s1);
    check("rst_mid_rd8", rd, 32'h0);
    bus_idle();
    apb_xfer(0, 32'h20, 32'h0, 4'h0, 0, rd, err, waits, s1);
    check("rst_mem_clear", rd, 32'h0);
    bus_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_slave_mem_param.md
# apb_slave_mem_param

Parametrised APB slave memory for the APB verification environment. It adds configurable data and address widths, configurable depth and wait states, byte-lane write strobes (PSTRB), an explicit transfer state machine with abort handling, and an optional PSLVERR error response. It sits behind an APB master or bridge as a zero-side-effect register/RAM target.

## Interface
- ADDR_WIDTH, 32: PADDR width.
- DATA_WIDTH, 32: PWDATA/PRDATA width; must be 8, 16 or 32.
- DEPTH, 256: number of DATA_WIDTH words; must be a power of two, at least 2.
- WAIT_CYCLES, 2: wait states inserted in every access phase; range 0..15.

Ports:
- PCLK  in  1  APB clock; all logic on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte strobes.
- PWRITE  in  1  1 = write, 0 = read.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase marker.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer-complete.
- PSLVERR  out  1  error response.

## Operation
- One clock domain. Reset is synchronous and active-high; the ports are PCLK and PRESET.
- Word index = PADDR >> log2(DATA_WIDTH/8). PADDR low bits below the word boundary are ignored.
- State machine has three states: IDLE, ACCESS, DONE.
  - IDLE: when PSEL=1 and PENABLE=0 (setup phase), latch PADDR, PWRITE and PSTRB, clear the wait counter, and go to ACCESS. PENABLE=1 without a preceding setup is ignored; the block stays in IDLE.
  - ACCESS: while PSEL=1 and PENABLE=1, increment the counter until it equals WAIT_CYCLES. PREADY=1 combinationally when the counter equals WAIT_CYCLES; the next state is then DONE.
  - DONE: a single cycle, then IDLE. If PSEL=1 and PENABLE=0 in DONE, treat it as a new setup and go directly to ACCESS, so back-to-back transfers are supported.
  - PSEL=0 in ACCESS aborts the transfer: go to IDLE, no write, PREADY stays 0.
- Write commits at the rising edge that ends the PREADY=1 cycle. For each lane i with PSTRB[i]=1, update byte i of the word; bytes with strobe 0 are unchanged. PSTRB=0 completes the transfer normally with no memory change.
- Read: PRDATA = mem[index] while PREADY=1 and the latched PWRITE=0; otherwise PRDATA = 0. PRDATA is never driven to Z.
- Address and control are sampled from the latched setup values. Changes on PADDR or PWRITE during ACCESS are ignored.

## Timing
- Reset values: state IDLE, counter 0, PREADY 0, PSLVERR 0, PRDATA 0, all memory words 0. Memory clear completes in the reset cycle.
- Reset asserted mid-transfer returns to IDLE on that edge. A pending write is dropped.
- Setup at cycle T; PREADY is high in cycle T+1+WAIT_CYCLES. With WAIT_CYCLES=0, PREADY is high in the first access cycle.
- Back-to-back: the next setup may occur in cycle T+2+WAIT_CYCLES, giving one transfer per WAIT_CYCLES+2 cycles.
- A read immediately after a write to the same address returns the new data.

## Configuration
- Macro: APB_SLV_PSLVERR_EN.
- Defined: a word index of DEPTH or more is out of range. PSLVERR=1 in the PREADY cycle for that transfer, the write is suppressed, and PRDATA=0. PSLVERR is 0 in all other cycles.
- Undefined: PSLVERR is tied to 0, and the index wraps modulo DEPTH (upper address bits ignored).

## Test plan
- Reset then read: PRESET high for 2 cycles, then read addr 0x10 → PRDATA=0x00000000, PREADY high in cycle T+3 with WAIT_CYCLES=2.
- Write/read: write 0xDEADBEEF to 0x20 with PSTRB=4'hF, then read 0x20 → 0xDEADBEEF. Then write 0x11223344 with PSTRB=4'b0101 and read → 0xDE22BE44.
- Abort: setup write 0xA5A5A5A5 to 0x30, drop PSEL on the first access cycle → PREADY never asserts, and a later read of 0x30 returns 0.
- Back-to-back: write 0x1 to 0x0 and 0x2 to 0x4 in consecutive transfers, with the second setup in the DONE cycle → both complete, 4 cycles per transfer, and reads return 0x1 and 0x2.
- Error: with APB_SLV_PSLVERR_EN, write to 0x400 (index 256, DEPTH=256) → PSLVERR=1 with PREADY, and a read of 0x0 is unchanged. Without the macro, the same write lands at index 0.
- Reset mid-write: assert PRESET during the wait state of a write to 0x8 → PREADY stays 0, and a read of 0x8 after reset returns 0.
